// File: rtl/comp_result_debounce_pkg.sv
// Shared definitions for the comparator result debouncer.
// Flag encodings use bit order {l,e,g}.
package comp_result_debounce_pkg;

  localparam logic [2:0] CMP_LT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_GT = 3'b001;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_QUAL   = 2'd1,
    ST_STABLE = 2'd2
  } state_e;

endpackage

// File: rtl/comp_result_debounce_onehot3_chk.sv
// Combinational legality check for a {l,e,g} flag triple.
// Legal only when exactly one flag is set.
module onehot3_chk
  import comp_result_debounce_pkg::*;
(
  input  logic [2:0] flags,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    unique case (1'b1)
      (flags == CMP_LT): legal = 1'b1;
      (flags == CMP_EQ): legal = 1'b1;
      (flags == CMP_GT): legal = 1'b1;
      default:           legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/comp_result_debounce.sv
// Debounces comparator flags: commits a result after STABLE_CNT
// consecutive identical legal samples, pulses change, counts commits.
module comp_result_debounce
  import comp_result_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  input  logic             clr,
  output logic             out_l,
  output logic             out_e,
  output logic             out_g,
  output logic             change,
  output logic             err,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int unsigned RW = $clog2(STABLE_CNT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(STABLE_CNT);

  logic [2:0]       smp;
  logic             legal;
  state_e           state_q, state_d;
  logic [2:0]       cand_q, cand_d;
  logic [2:0]       res_q, res_d;
  logic [RW-1:0]    run_q, run_d;
  logic [RW-1:0]    run_nxt;
  logic             commit;
  logic             change_q, change_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign smp = {l, e, g};

  onehot3_chk u_chk (
    .flags (smp),
    .legal (legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      cand_q   <= '0;
      res_q    <= '0;
      run_q    <= '0;
      change_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      res_q    <= res_d;
      run_q    <= run_d;
      change_q <= change_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    res_d    = res_q;
    run_d    = run_q;
    change_d = 1'b0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    run_nxt  = RW'(1);
    commit   = 1'b0;

    unique case (1'b1)
      (in_valid && legal): begin
        if (run_q != '0 && smp == cand_q) begin
          run_nxt = (run_q >= RUN_MAX) ? RUN_MAX
                                       : run_q + RW'(1);
        end
        commit = (run_nxt == RUN_MAX) && (smp != res_q);
        cand_d = smp;
        run_d  = run_nxt;
        if (commit) begin
          res_d    = smp;
          change_d = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Returning to the committed value settles without a pulse.
        state_d = (commit || smp == res_q) ? ST_STABLE
                                           : ST_QUAL;
      end
      (in_valid && !legal): begin
        err_d  = 1'b1;
        cand_d = '0;
        run_d  = '0;
      end
      default: ;
    endcase

    if (clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end
  end

  assign {out_l, out_e, out_g} = res_q;
  assign change  = change_q;
  assign err     = err_q;
  assign evt_cnt = cnt_q;

endmodule

// File: tb/tb_comp_result_debounce.sv
// Directed bench for comp_result_debounce.
// Second instance covers STABLE_CNT=1 and a 2-bit saturating count.
module tb_comp_result_debounce;
  import comp_result_debounce_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] s = 3'b000;
  logic       clr = 1'b0;
  logic       out_l, out_e, out_g, change, err;
  logic [7:0] evt_cnt;
  logic [2:0] out;

  logic       in_valid2 = 1'b0;
  logic [2:0] s2 = 3'b000;
  logic       clr2 = 1'b0;
  logic       out_l2, out_e2, out_g2, change2, err2;
  logic [1:0] evt_cnt2;
  logic [2:0] out2;

  int asserts = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign out  = {out_l, out_e, out_g};
  assign out2 = {out_l2, out_e2, out_g2};

  comp_result_debounce #(.STABLE_CNT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .l(s[2]), .e(s[1]), .g(s[0]), .clr(clr),
    .out_l(out_l), .out_e(out_e), .out_g(out_g),
    .change(change), .err(err), .evt_cnt(evt_cnt)
  );

  comp_result_debounce #(.STABLE_CNT(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2),
    .l(s2[2]), .e(s2[1]), .g(s2[0]), .clr(clr2),
    .out_l(out_l2), .out_e(out_e2), .out_g(out_g2),
    .change(change2), .err(err2), .evt_cnt(evt_cnt2)
  );

  task automatic step(input logic v, input logic [2:0] smp);
    in_valid = v;
    s = smp;
    @(posedge clk);
    #1;
  endtask

  task automatic step2(input logic v, input logic [2:0] smp);
    in_valid2 = v;
    s2 = smp;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    asserts++;
    if ({out, change, err, evt_cnt} !== 13'd0) begin
      fails++;
      $display("FAIL reset: out=%b chg=%b err=%b cnt=%0d want 0",
               out, change, err, evt_cnt);
    end
    asserts++;
    if ({out2, change2, err2, evt_cnt2} !== 7'd0) begin
      fails++;
      $display("FAIL reset2: out=%b chg=%b err=%b cnt=%0d want 0",
               out2, change2, err2, evt_cnt2);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_commit();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, CMP_EQ);
      asserts++;
      if (out !== 3'b000 || change !== 1'b0) begin
        fails++;
        $display("FAIL eq_early[%0d]: out=%b chg=%b want 000 0",
                 i, out, change);
      end
    end
    step(1'b1, CMP_EQ);
    asserts++;
    if (out !== CMP_EQ || change !== 1'b1 || evt_cnt !== 8'd1) begin
      fails++;
      $display("FAIL eq_commit: out=%b chg=%b cnt=%0d want 010 1 1",
               out, change, evt_cnt);
    end
    step(1'b0, 3'b000);
    asserts++;
    if (change !== 1'b0 || out !== CMP_EQ) begin
      fails++;
      $display("FAIL eq_pulse: chg=%b out=%b want 0 010", change, out);
    end
  endtask

  task automatic test_requalify();
    logic [3:0][2:0] pre;
    pre[0] = CMP_GT; pre[1] = CMP_GT; pre[2] = CMP_GT; pre[3] = CMP_EQ;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, pre[i]);
      asserts++;
      if (out !== CMP_EQ || change !== 1'b0) begin
        fails++;
        $display("FAIL requal_pre[%0d]: out=%b chg=%b want 010 0",
                 i, out, change);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, CMP_GT);
      asserts++;
      if (out !== CMP_EQ || change !== 1'b0) begin
        fails++;
        $display("FAIL requal_gt[%0d]: out=%b chg=%b want 010 0",
                 i, out, change);
      end
    end
    step(1'b1, CMP_GT);
    asserts++;
    if (out !== CMP_GT || change !== 1'b1 || evt_cnt !== 8'd2) begin
      fails++;
      $display("FAIL requal_commit: out=%b chg=%b cnt=%0d want 001 1 2",
               out, change, evt_cnt);
    end
  endtask

  task automatic test_gaps();
    step(1'b1, CMP_EQ);
    step(1'b1, CMP_EQ);
    for (int i = 0; i < 5; i++) step(1'b0, CMP_LT);
    step(1'b1, CMP_EQ);
    asserts++;
    if (out !== CMP_GT || change !== 1'b0) begin
      fails++;
      $display("FAIL gap_early: out=%b chg=%b want 001 0", out, change);
    end
    step(1'b1, CMP_EQ);
    asserts++;
    if (out !== CMP_EQ || change !== 1'b1 || evt_cnt !== 8'd3) begin
      fails++;
      $display("FAIL gap_commit: out=%b chg=%b cnt=%0d want 010 1 3",
               out, change, evt_cnt);
    end
  endtask

  task automatic test_illegal();
    step(1'b1, CMP_LT);
    step(1'b1, CMP_LT);
    step(1'b1, 3'b110);
    asserts++;
    if (err !== 1'b1 || out !== CMP_EQ || change !== 1'b0) begin
      fails++;
      $display("FAIL ill_110: err=%b out=%b chg=%b want 1 010 0",
               err, out, change);
    end
    step(1'b1, 3'b000);
    asserts++;
    if (err !== 1'b1 || out !== CMP_EQ) begin
      fails++;
      $display("FAIL ill_000: err=%b out=%b want 1 010", err, out);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, CMP_LT);
      asserts++;
      if (out !== CMP_EQ || change !== 1'b0 || err !== 1'b1) begin
        fails++;
        $display("FAIL ill_fresh[%0d]: out=%b chg=%b err=%b want 010 0 1",
                 i, out, change, err);
      end
    end
    step(1'b1, CMP_LT);
    asserts++;
    if (out !== CMP_LT || change !== 1'b1 || evt_cnt !== 8'd4) begin
      fails++;
      $display("FAIL ill_commit: out=%b chg=%b cnt=%0d want 100 1 4",
               out, change, evt_cnt);
    end
    clr = 1'b1;
    step(1'b1, 3'b011);
    clr = 1'b0;
    asserts++;
    if (err !== 1'b0 || evt_cnt !== 8'd0 || out !== CMP_LT) begin
      fails++;
      $display("FAIL clr_prio: err=%b cnt=%0d out=%b want 0 0 100",
               err, evt_cnt, out);
    end
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < 3; i++) step(1'b1, CMP_GT);
    #2;
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({out, change, err, evt_cnt} !== 13'd0) begin
      fails++;
      $display("FAIL async_rst: out=%b chg=%b err=%b cnt=%0d want 0",
               out, change, err, evt_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, CMP_GT);
      asserts++;
      if (out !== 3'b000 || change !== 1'b0) begin
        fails++;
        $display("FAIL rst_run[%0d]: out=%b chg=%b want 000 0",
                 i, out, change);
      end
    end
    step(1'b1, CMP_GT);
    asserts++;
    if (out !== CMP_GT || change !== 1'b1 || evt_cnt !== 8'd1) begin
      fails++;
      $display("FAIL rst_commit: out=%b chg=%b cnt=%0d want 001 1 1",
               out, change, evt_cnt);
    end
    step(1'b0, 3'b000);
  endtask

  task automatic test_saturate();
    logic [4:0][2:0] seq;
    logic [4:0][1:0] want;
    seq[0] = CMP_LT; seq[1] = CMP_GT; seq[2] = CMP_LT;
    seq[3] = CMP_GT; seq[4] = CMP_LT;
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3;
    want[3] = 2'd3; want[4] = 2'd3;
    for (int i = 0; i < 5; i++) begin
      step2(1'b1, seq[i]);
      asserts++;
      if (out2 !== seq[i] || change2 !== 1'b1 || evt_cnt2 !== want[i]) begin
        fails++;
        $display("FAIL sat[%0d]: out=%b chg=%b cnt=%0d want %b 1 %0d",
                 i, out2, change2, evt_cnt2, seq[i], want[i]);
      end
    end
    step2(1'b1, CMP_LT);
    asserts++;
    if (change2 !== 1'b0 || evt_cnt2 !== 2'd3) begin
      fails++;
      $display("FAIL sat_same: chg=%b cnt=%0d want 0 3", change2, evt_cnt2);
    end
    clr2 = 1'b1;
    step2(1'b0, 3'b000);
    clr2 = 1'b0;
    asserts++;
    if (evt_cnt2 !== 2'd0 || out2 !== CMP_LT) begin
      fails++;
      $display("FAIL sat_clr: cnt=%0d out=%b want 0 100", evt_cnt2, out2);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_first_commit();
    test_requalify();
    test_gaps();
    test_illegal();
    test_reset_midrun();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
